// File: rtl/ddr3_tester_pkg.sv
// Shared definitions for the DDR3 memory tester: FSM encoding and line geometry.
package ddr3_tester_pkg;

  // Size of one inport transfer in bytes (one 128-bit line)
  localparam int LINE_BYTES     = 16;
  localparam int LINE_SHIFT     = $clog2(LINE_BYTES);
  localparam int WORDS_PER_LINE = LINE_BYTES / 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WDRAIN = 3'd2,
    ST_READ   = 3'd3,
    ST_RDRAIN = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Address-derived test pattern: line address = base + idx*16, and each 32-bit
// word k of the line is (address + 4k) XOR seed. Purely combinational.
module ddr3_pattern_gen
  import ddr3_tester_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [31:0]      base_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic [31:0]      seed_i,
  output logic [31:0]      addr_o,
  output logic [127:0]     data_o
);

  logic [31:0] w_offset;

  // Line offset wraps modulo 2^32 together with the base addition
  assign w_offset = 32'(idx_i) << LINE_SHIFT;
  assign addr_o   = base_i + w_offset;

  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      assign data_o[32*gi +: 32] = (addr_o + 32'(4 * gi)) ^ seed_i;
    end
  endgenerate

endmodule

// File: rtl/ddr3_mem_tester.sv
// Self-checking write-then-read traffic engine for the ddr3_core inport.
// Writes a pattern over N lines, waits for all write acks, reads the lines
// back with a bounded number of outstanding reads and checks every response.
module ddr3_mem_tester
  import ddr3_tester_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [31:0]        base_addr_i,
  input  logic [CNT_W-1:0]   num_lines_i,
  input  logic [31:0]        seed_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [31:0]        fail_addr_o,
  output logic [15:0]        inport_wr_o,
  output logic               inport_rd_o,
  output logic [31:0]        inport_addr_o,
  output logic [127:0]       inport_write_data_o,
  output logic [CNT_W-1:0]   inport_req_id_o,
  input  logic               inport_accept_i,
  input  logic               inport_ack_i,
  input  logic               inport_error_i,
  input  logic [CNT_W-1:0]   inport_resp_id_i,
  input  logic [127:0]       inport_read_data_i
);

  // Outstanding counter is wide enough for any MAX_OUTSTANDING in 1..15
  localparam int OUT_W = 4;

  state_t           r_state;
  logic [31:0]      r_base;
  logic [31:0]      r_seed;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_issue_idx;
  logic [CNT_W-1:0] r_ack_cnt;
  logic [CNT_W-1:0] r_err_count;
  logic [31:0]      r_fail_addr;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [31:0]      w_issue_addr;
  logic [127:0]     w_issue_data;
  logic [31:0]      w_chk_addr;
  logic [127:0]     w_chk_data;
  logic             w_req_wr;
  logic             w_req_rd;
  logic             w_accept;
  logic             w_rd_accept;
  logic             w_last_issue;
  logic             w_wr_ack;
  logic             w_rd_ack;
  logic             w_err_ev;

  // Issue path: pattern for the line currently being requested
  ddr3_pattern_gen #(.CNT_W(CNT_W)) u_issue_gen (
    .base_i (r_base),
    .idx_i  (r_issue_idx),
    .seed_i (r_seed),
    .addr_o (w_issue_addr),
    .data_o (w_issue_data)
  );

  // Check path: expected line regenerated from the response id
  ddr3_pattern_gen #(.CNT_W(CNT_W)) u_check_gen (
    .base_i (r_base),
    .idx_i  (inport_resp_id_i),
    .seed_i (r_seed),
    .addr_o (w_chk_addr),
    .data_o (w_chk_data)
  );

  // A read stays presented once shown: the outstanding count can only grow
  // through its own accept, so the request cannot be withdrawn early.
  assign w_req_wr     = (r_state == ST_WRITE);
  assign w_req_rd     = (r_state == ST_READ) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign w_accept     = (w_req_wr || w_req_rd) && inport_accept_i;
  assign w_rd_accept  = w_req_rd && inport_accept_i;
  assign w_last_issue = (r_issue_idx == (r_num - CNT_W'(1)));
  assign w_wr_ack     = inport_ack_i && ((r_state == ST_WRITE) || (r_state == ST_WDRAIN));
  assign w_rd_ack     = inport_ack_i && ((r_state == ST_READ) || (r_state == ST_RDRAIN));
  assign w_err_ev     = (w_wr_ack && inport_error_i) ||
                        (w_rd_ack && (inport_error_i || (inport_read_data_i != w_chk_data)));

  assign inport_wr_o         = w_req_wr ? 16'hFFFF : 16'h0000;
  assign inport_rd_o         = w_req_rd;
  assign inport_addr_o       = (w_req_wr || w_req_rd) ? w_issue_addr : 32'h0;
  assign inport_write_data_o = w_req_wr ? w_issue_data : 128'h0;
  assign inport_req_id_o     = (w_req_wr || w_req_rd) ? r_issue_idx : '0;

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign err_count_o = r_err_count;
  assign fail_addr_o = r_fail_addr;

  // Test sequencer: issue, ack accounting, error capture and completion status
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_base        <= 32'h0;
      r_seed        <= 32'h0;
      r_num         <= '0;
      r_issue_idx   <= '0;
      r_ack_cnt     <= '0;
      r_err_count   <= '0;
      r_fail_addr   <= 32'h0;
      r_outstanding <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_wr_ack || w_rd_ack) begin
        r_ack_cnt <= r_ack_cnt + CNT_W'(1);
      end

      // First failure is the one seen while the count is still zero
      if (w_err_ev) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
        if (r_err_count == '0) begin
          r_fail_addr <= w_chk_addr;
        end
      end

      case ({w_rd_accept, w_rd_ack})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_base        <= base_addr_i & 32'hFFFF_FFF0;
            r_seed        <= seed_i;
            r_num         <= num_lines_i;
            r_issue_idx   <= '0;
            r_ack_cnt     <= '0;
            r_outstanding <= '0;
            r_err_count   <= '0;
            r_fail_addr   <= 32'h0;
            if (num_lines_i == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_WRITE;
              r_pass  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (w_accept) begin
            if (w_last_issue) begin
              r_issue_idx <= '0;
              r_state     <= ST_WDRAIN;
            end else begin
              r_issue_idx <= r_issue_idx + CNT_W'(1);
            end
          end
        end
        ST_WDRAIN: begin
          if (r_ack_cnt == r_num) begin
            r_ack_cnt <= '0;
            r_state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_accept) begin
            if (w_last_issue) begin
              r_issue_idx <= '0;
              r_state     <= ST_RDRAIN;
            end else begin
              r_issue_idx <= r_issue_idx + CNT_W'(1);
            end
          end
        end
        ST_RDRAIN: begin
          if (r_ack_cnt == r_num) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == '0);
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_mem_tester.sv
// Bench for ddr3_mem_tester: behavioural inport memory with random accept and
// delayed acks, request and result scoreboards, directed test sequence.
module tb_ddr3_mem_tester;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [31:0]  base_addr_i;
  logic [15:0]  num_lines_i;
  logic [31:0]  seed_i;
  logic         busy_o, done_o, pass_o;
  logic [15:0]  err_count_o;
  logic [31:0]  fail_addr_o;
  logic [15:0]  inport_wr_o;
  logic         inport_rd_o;
  logic [31:0]  inport_addr_o;
  logic [127:0] inport_write_data_o;
  logic [15:0]  inport_req_id_o;
  logic         inport_accept_i;
  logic         inport_ack_i;
  logic         inport_error_i;
  logic [15:0]  inport_resp_id_i;
  logic [127:0] inport_read_data_i;

  ddr3_mem_tester #(.MAX_OUTSTANDING(4), .CNT_W(16)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start_i),
    .base_addr_i         (base_addr_i),
    .num_lines_i         (num_lines_i),
    .seed_i              (seed_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .pass_o              (pass_o),
    .err_count_o         (err_count_o),
    .fail_addr_o         (fail_addr_o),
    .inport_wr_o         (inport_wr_o),
    .inport_rd_o         (inport_rd_o),
    .inport_addr_o       (inport_addr_o),
    .inport_write_data_o (inport_write_data_o),
    .inport_req_id_o     (inport_req_id_o),
    .inport_accept_i     (inport_accept_i),
    .inport_ack_i        (inport_ack_i),
    .inport_error_i      (inport_error_i),
    .inport_resp_id_i    (inport_resp_id_i),
    .inport_read_data_i  (inport_read_data_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int           due;
    logic [15:0]  id;
    logic [127:0] data;
    logic         is_rd;
  } resp_t;

  int           errors = 0;
  int           checks = 0;
  logic [127:0] mem [logic [31:0]];
  resp_t        resp_q [$];
  logic [192:0] exp_req [$];
  logic [48:0]  exp_done [$];
  int           accept_pct = 100;
  int           ack_delay = 2;
  bit           corrupt_en = 0;
  logic [31:0]  corrupt_addr = 32'h0;
  int           stab_viol = 0;
  int           unexp = 0;
  int           max_out = 0;
  int           out_cnt = 0;
  int           last_lat = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a, input logic [31:0] s);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = (a + 32'(4 * k)) ^ s;
    return r;
  endfunction

  // Behavioural memory: decides accept and ack at the falling edge
  initial begin
    int           cyc;
    logic [192:0] cur, prev_req, e;
    bit           prev_pending, acc_now, ack_rd;
    resp_t        r;
    cyc = 0; prev_pending = 0; prev_req = '0;
    inport_accept_i = 0; inport_ack_i = 0; inport_error_i = 0;
    inport_resp_id_i = '0; inport_read_data_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        resp_q.delete();
        inport_accept_i = 0; inport_ack_i = 0; inport_error_i = 0;
        inport_resp_id_i = '0; inport_read_data_i = '0;
        prev_pending = 0; out_cnt = 0;
        continue;
      end
      cur = {inport_wr_o, inport_rd_o, inport_addr_o, inport_write_data_o, inport_req_id_o};
      if (prev_pending && cur !== prev_req) stab_viol++;
      inport_ack_i = 0; ack_rd = 0;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        r = resp_q.pop_front();
        inport_ack_i = 1; inport_resp_id_i = r.id;
        inport_read_data_i = r.data; ack_rd = r.is_rd;
      end
      acc_now = 0;
      if (inport_wr_o != 16'h0 || inport_rd_o) begin
        acc_now = ($urandom_range(99) < accept_pct);
        if (acc_now) begin
          if (exp_req.size() == 0) unexp++;
          else begin
            e = exp_req.pop_front();
            check($sformatf("req_id%0d", inport_req_id_o), cur, e);
          end
          r.due = cyc + ack_delay; r.id = inport_req_id_o; r.is_rd = inport_rd_o;
          if (inport_rd_o) begin
            r.data = mem.exists(inport_addr_o) ? mem[inport_addr_o] : 128'h0;
            if (corrupt_en && inport_addr_o == corrupt_addr) r.data[0] = ~r.data[0];
            out_cnt++;
          end else begin
            mem[inport_addr_o] = inport_write_data_o;
            r.data = 128'h0;
          end
          resp_q.push_back(r);
        end
      end
      inport_accept_i = acc_now;
      if (ack_rd) out_cnt--;
      if (out_cnt > max_out) max_out = out_cnt;
      prev_pending = (inport_wr_o != 16'h0 || inport_rd_o) && !acc_now;
      prev_req = cur;
    end
  end

  task automatic run_test(input string name, input logic [31:0] base, input logic [15:0] n,
                          input logic [31:0] seed, input logic exp_pass, input logic [15:0] exp_err,
                          input logic [31:0] exp_fail, input bit mid_start);
    logic [31:0] ab, a;
    logic [48:0] ed;
    bit got;
    ab = base & 32'hFFFF_FFF0;
    for (int i = 0; i < n; i++) begin
      a = ab + 32'(i) * 32'd16;
      exp_req.push_back({16'hFFFF, 1'b0, a, line_of(a, seed), 16'(i)});
    end
    for (int i = 0; i < n; i++) begin
      a = ab + 32'(i) * 32'd16;
      exp_req.push_back({16'h0000, 1'b1, a, 128'h0, 16'(i)});
    end
    exp_done.push_back({exp_pass, exp_err, exp_fail});
    stab_viol = 0; unexp = 0; max_out = 0; mem.delete();
    @(posedge clk); #1;
    base_addr_i = base; num_lines_i = n; seed_i = seed; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    if (mid_start) begin
      @(posedge clk); #1;
      base_addr_i = 32'h9000; num_lines_i = 16'd1; start_i = 1;
      @(posedge clk); #1;
      start_i = 0;
      check({name, "_busy_ignore_start"}, busy_o, 1'b1);
    end
    got = done_o; last_lat = 0;
    while (!got && last_lat < 5000) begin
      @(posedge clk); #1;
      last_lat++;
      got = done_o;
    end
    check({name, "_done_seen"}, got, 1'b1);
    ed = exp_done.pop_front();
    check({name, "_result"}, {pass_o, err_count_o, fail_addr_o}, ed);
    check({name, "_busy_low"}, busy_o, 1'b0);
    check({name, "_reqs_left"}, exp_req.size(), 0);
    check({name, "_stable"}, stab_viol, 0);
    check({name, "_unexpected"}, unexp, 0);
    check({name, "_max_out"}, (max_out <= 4), 1'b1);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, {done_o, pass_o}, {1'b0, exp_pass});
    $display("test %s: base=%08h n=%0d pass=%0b err=%0d fail_addr=%08h lat=%0d",
             name, base, n, pass_o, err_count_o, fail_addr_o, last_lat);
  endtask

  initial begin
    bit seen;
    rst = 1; start_i = 0; base_addr_i = '0; num_lines_i = '0; seed_i = '0;
    #1;
    check("reset_outputs", {busy_o, done_o, pass_o, err_count_o, fail_addr_o, inport_wr_o,
          inport_rd_o, inport_addr_o, inport_write_data_o, inport_req_id_o}, 256'h0);
    repeat (3) @(posedge clk);
    #2 rst = 0;

    run_test("basic", 32'h0, 16'd3, 32'h0, 1'b1, 16'd0, 32'h0, 0);
    check("basic_line0", mem[32'h0], 128'h0000000c_00000008_00000004_00000000);

    run_test("seedbase", 32'h0000_1007, 16'd2, 32'hA5A5A5A5, 1'b1, 16'd0, 32'h0, 0);
    check("seedbase_line1_word0", mem[32'h1010][31:0], 32'hA5A5B5B5);

    corrupt_en = 1; corrupt_addr = 32'h2050;
    run_test("corrupt", 32'h2000, 16'd8, 32'h12345678, 1'b0, 16'd1, 32'h2050, 1);
    corrupt_en = 0;

    accept_pct = 50; ack_delay = 20;
    run_test("backpressure", 32'h4000, 16'd12, 32'hDEADBEEF, 1'b1, 16'd0, 32'h0, 0);
    check("backpressure_out_reached", max_out, 4);
    accept_pct = 100; ack_delay = 2;

    run_test("zero_lines", 32'h100, 16'd0, 32'h1, 1'b1, 16'd0, 32'h0, 0);
    check("zero_lines_latency", last_lat, 0);

    run_test("wrap", 32'hFFFF_FFF0, 16'd2, 32'h0, 1'b1, 16'd0, 32'h0, 0);
    check("wrap_line1_at_0", mem.exists(32'h0), 1'b1);

    // Reset while reads are in flight
    ack_delay = 20;
    @(posedge clk); #1;
    base_addr_i = 32'h8000; num_lines_i = 16'd16; seed_i = 32'h5; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk); #1;
      seen = inport_rd_o;
    end
    check("rst_read_seen", seen, 1'b1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    check("rst_mid_outputs", {busy_o, done_o, pass_o, err_count_o, fail_addr_o, inport_wr_o,
          inport_rd_o, inport_addr_o, inport_write_data_o, inport_req_id_o}, 256'h0);
    exp_req.delete();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    ack_delay = 2;
    $display("reset mid-read applied");
    run_test("after_reset", 32'h8000, 16'd16, 32'h5, 1'b1, 16'd0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr3_mem_tester.md
Name: ddr3_mem_tester

Overview:
Self-checking traffic engine that sits directly upstream of ddr3_core and drives its 128-bit inport request/response interface. On start it writes a deterministic address-derived pattern to a contiguous range of 16-byte lines, waits for all write acks, then reads the range back and compares. It reports pass/fail, a saturating error count and the first failing line address. It is used for board bring-up and regression in place of a CPU/bus master.

Parameters:
MAX_OUTSTANDING, 4, maximum read requests accepted but not yet acked (1..15)
CNT_W, 16, width of line counter, num_lines_i and req_id

Ports:
clk_i  in  1  system clock (DFI-side clock of ddr3_core)
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start test; sampled only in IDLE or DONE
base_addr_i  in  32  byte base address; bits [3:0] ignored (forced 0)
num_lines_i  in  CNT_W  number of 128-bit lines to test
seed_i  in  32  pattern seed
busy_o  out  1  test in progress
done_o  out  1  one-cycle pulse at test completion
pass_o  out  1  valid from done_o until next start; 1 = no errors
err_count_o  out  CNT_W  mismatching/errored reads, saturates at all-ones
fail_addr_o  out  32  address of first failing line (0 if none)
inport_wr_o  out  16  byte write strobes (16'hFFFF for write, 0 otherwise)
inport_rd_o  out  1  read request
inport_addr_o  out  32  request byte address
inport_write_data_o  out  128  write data
inport_req_id_o  out  CNT_W  request id = line index
inport_accept_i  in  1  request accepted this cycle
inport_ack_i  in  1  response valid
inport_error_i  in  1  response error
inport_resp_id_i  in  CNT_W  id of response
inport_read_data_i  in  128  read data

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Pattern: line idx at A = base + idx*16 (mod 2^32); word k (bits 32k+31:32k, k=0..3) = (A + 4k) XOR seed. Purely combinational from address and seed.
- Request rule: inport_wr_o/inport_rd_o, address, data and id are held stable until the cycle where inport_accept_i=1. The next request may be presented in the following cycle. At most one of wr/rd is nonzero.
- States:
  - IDLE/DONE: start_i=1 latches base, num_lines and seed; clears err_count, fail_addr and pass. Sets busy_o. If num_lines=0, goes to DONE next cycle with done_o=1 and pass_o=1. Otherwise goes to WRITE.
  - WRITE: issues writes for idx 0..N-1 back-to-back, gated by accept. After the last accept, goes to WDRAIN.
  - WDRAIN: waits until write-ack count equals N, then goes to READ. A write ack with inport_error_i=1 counts as an error and records fail_addr if it is the first.
  - READ: issues reads while outstanding < MAX_OUTSTANDING. Outstanding increments on accept and decrements on ack; a same-cycle accept and ack leave it unchanged. After the last read accept, goes to RDRAIN.
  - RDRAIN: when read-ack count equals N, goes to DONE. done_o pulses 1 cycle, pass_o = (err_count==0), busy_o drops.
- Check (READ/RDRAIN acks): the expected line is regenerated from inport_resp_id_i. A mismatch in any bit, or inport_error_i=1, increments err_count (saturating). The first failure loads fail_addr_o = base + resp_id*16.
- Acks in IDLE/DONE are ignored.
- start_i while busy is ignored.
- Async reset mid-test: everything returns to reset values immediately; no further requests issue.
- Line counters wrap-free. Address arithmetic wraps modulo 2^32.

Decomposition:
- Shared package ddr3_tester_pkg: state encoding (IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE) and LINE_BYTES=16.
- Sub-module ddr3_pattern_gen: combinational (base, idx, seed) -> {addr, 128-bit data}. It is instantiated twice, once for the issue path and once for the check path.

Test Plan:
- Basic pass: base=0, N=3, seed=0 against ddr3_core plus DDR3 model. Line 0 = 128'h0000000c_00000008_00000004_00000000. Required: done_o pulses, pass_o=1, err_count_o=0, fail_addr_o=0.
- Seed/base: base=32'h0000_1007, N=2, seed=32'hA5A5A5A5. Required: addresses 0x1000 and 0x1010; word0 of line1 = 0xA5A5B5B5; pass_o=1.
- Corruption: behavioural memory flips bit 0 of line 5 of N=8. Required: err_count_o=1, fail_addr_o=base+0x50, pass_o=0.
- Backpressure/outstanding: accept randomly deasserted, ack delayed 20 cycles, MAX_OUTSTANDING=4. Required: outstanding never exceeds 4, requests stay stable while unaccepted, pass_o=1.
- Edge cases: N=0 gives done_o on the cycle after start with pass_o=1 and no requests. start_i asserted while busy has no effect. base=32'hFFFF_FFF0 with N=2 wraps the second line to address 0.
- Reset mid-READ: assert rst_i asynchronously between clock edges. Required: all outputs are 0 immediately; a new start runs a full clean test to pass.
